// File: rtl/cic_pkg.sv
// Shared constants, sample type and saturation helper for the CIC
// decimating output stage.
package cic_pkg;

  localparam int CIC_DECIM      = 32;  // oversample length of the CIC
  localparam int CIC_IN_W       = 12;  // CIC running output width
  localparam int CIC_OUT_W      = 16;  // decimated output sample width
  localparam int CIC_DC_SHIFT   = 6;   // DC tracking time constant exponent
  localparam int CIC_FIFO_DEPTH = 4;   // output FIFO entries

  typedef logic signed [CIC_OUT_W-1:0] cic_sample_t;

  // Clamp a signed value into the range of a w-bit two's complement number.
  // The result stays 32 bits wide; callers keep the low w bits.
  function automatic logic signed [31:0] sat_to_width(input logic signed [31:0] v,
                                                       input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/cic_decim_out_if.sv
// Output stream toward the bus/beamforming logic.
// Handshake: out_data is meaningful whenever out_valid is high; a transfer
// (pop) happens on every rising clk edge where out_valid and out_ready are
// both high. The producer never withdraws out_valid without a transfer.
interface cic_decim_out_if #(
  parameter int OUT_W = cic_pkg::CIC_OUT_W
) ();

  logic                    out_valid;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_ready;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);

endinterface

// File: rtl/cic_out_fifo.sv
// First-word fall-through output FIFO with occupancy count and sticky
// overflow flag. A push into a full FIFO is kept only when a pop happens in
// the same cycle; otherwise the sample is dropped and overflow is set.
module cic_out_fifo
  import cic_pkg::*;
#(
  parameter int DEPTH = CIC_FIFO_DEPTH,
  parameter int W     = CIC_OUT_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic signed [W-1:0]       push_data,
  input  logic                      pop_ready,
  input  logic                      clr_ovf,
  output logic                      out_valid,
  output logic signed [W-1:0]       out_data,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic signed [W-1:0] mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic                full;
  logic                pop;
  logic                wr_en;
  logic                drop;

  assign out_valid = (level != '0);
  assign full      = (level == LW'(DEPTH));
  assign pop       = out_valid && pop_ready;
  assign wr_en     = push && (!full || pop);
  assign drop      = push && full && !pop;
  // Empty FIFO presents zero so the output is clean after reset.
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  // Sample storage; contents are only visible through out_valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap modulo DEPTH; level tracks push minus pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      level <= level + LW'(wr_en) - LW'(pop);
    end
  end

  // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/cic_decim_out.sv
// Decimating output stage behind the PDM CIC demodulator. Keeps one CIC
// sample every DECIM strobes, scales it to OUT_W bits and queues it in a
// small FWFT FIFO.
// Optional DC blocker (leaky-integrator high-pass with saturation) is
// compiled in when CIC_DECIM_DC_BLOCK_EN is defined; otherwise the scaled
// sample is passed straight through.
module cic_decim_out
  import cic_pkg::*;
#(
  parameter int DECIM      = CIC_DECIM,
  parameter int IN_W       = CIC_IN_W,
  parameter int OUT_W      = CIC_OUT_W,
  parameter int DC_SHIFT   = CIC_DC_SHIFT,
  parameter int FIFO_DEPTH = CIC_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          in_valid,
  input  logic signed [IN_W-1:0]        din,
  cic_decim_out_if.master               out_if,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  input  logic                          clr_ovf
);

  localparam int PH_W = $clog2(DECIM);

  logic [PH_W-1:0]         phase;
  logic                    capture;
  logic signed [OUT_W-1:0] x_next;
  logic signed [OUT_W-1:0] x_q;
  logic                    x_vld;
  logic signed [OUT_W-1:0] y;

  assign capture = enable && in_valid && (phase == PH_W'(DECIM - 1));
  // Appending zeros is sign-extension followed by a left shift of
  // OUT_W-IN_W: the bits shifted out are copies of the sign.
  assign x_next  = {din, {(OUT_W - IN_W){1'b0}}};

  // Strobe phase counter; held at 0 while disabled so enabling starts a
  // fresh decimation window. DECIM is a power of two, so it wraps naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase <= '0;
    end else if (!enable) begin
      phase <= '0;
    end else if (in_valid) begin
      phase <= phase + PH_W'(1);
    end
  end

  // Capture stage (E0): register the scaled sample of the last strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q   <= '0;
      x_vld <= 1'b0;
    end else begin
      x_vld <= capture;
      if (capture) begin
        x_q <= x_next;
      end
    end
  end

`ifdef CIC_DECIM_DC_BLOCK_EN
  localparam int DC_W  = OUT_W + DC_SHIFT;
  localparam int ERR_W = OUT_W + 1;

  logic signed [DC_W-1:0]  dc;
  logic signed [OUT_W-1:0] dc_est;
  logic signed [ERR_W-1:0] err;

  // Current DC estimate is the accumulator scaled down by 2^DC_SHIFT.
  assign dc_est = dc[DC_W-1:DC_SHIFT];
  // One extra bit so the difference of two full-scale samples cannot wrap.
  assign err    = ERR_W'(x_q) - ERR_W'(dc_est);
  assign y      = OUT_W'(sat_to_width(32'(err), OUT_W));

  // Leaky integrator; only advances on output samples, so it holds while
  // the block is disabled. Wraps inside DC_W bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dc <= '0;
    end else if (x_vld) begin
      dc <= dc + DC_W'(err);
    end
  end
`else
  // Without the DC path the scaled input always fits and DC_SHIFT has no
  // effect.
  if (DC_SHIFT >= 0) begin : g_pass
    assign y = x_q;
  end
`endif

  // Result stage (E1): the FIFO write happens on the edge after capture.
  cic_out_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (OUT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (x_vld),
    .push_data (y),
    .pop_ready (out_if.out_ready),
    .clr_ovf   (clr_ovf),
    .out_valid (out_if.out_valid),
    .out_data  (out_if.out_data),
    .level     (level),
    .overflow  (overflow)
  );

endmodule

// File: tb/tb_cic_decim_out.sv
// Directed bench for cic_decim_out. Works with or without
// CIC_DECIM_DC_BLOCK_EN; the DC-path sequences are only built with it.
module tb_cic_decim_out;
  import cic_pkg::*;

  localparam int DECIM    = 32;
  localparam int DC_SHIFT = 6;
  localparam int DC_W     = 16 + DC_SHIFT;

`ifdef CIC_DECIM_DC_BLOCK_EN
  localparam int EXP_W2 = 1575;
  localparam int EXP_W3 = 1551;
  localparam int EXP_W4 = 1527;
`else
  localparam int EXP_W2 = 1600;
  localparam int EXP_W3 = 1600;
  localparam int EXP_W4 = 1600;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  logic enable;
  logic in_valid;
  logic signed [11:0] din;
  logic [2:0] level;
  logic overflow;
  logic clr_ovf;

  always #5 clk = ~clk;

  cic_decim_out_if #(.OUT_W(16)) bus ();

  cic_decim_out dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .in_valid (in_valid),
    .din      (din),
    .out_if   (bus),
    .level    (level),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
  );

  // scoreboard
  cic_sample_t exp_q[$];
  int checks = 0;
  int errors = 0;

`ifdef CIC_DECIM_DC_BLOCK_EN
  longint dc_m;
  logic signed [15:0] y;
  logic signed [15:0] prev;
`endif

  // Reference output for one captured, already scaled sample x.
  function automatic int model_y(input int x);
`ifdef CIC_DECIM_DC_BLOCK_EN
    longint err;
    longint s;
    err = longint'(x) - (dc_m >>> DC_SHIFT);
    s = (dc_m + err) & ((64'sd1 <<< DC_W) - 64'sd1);
    if (s >= (64'sd1 <<< (DC_W - 1))) s = s - (64'sd1 <<< DC_W);
    dc_m = s;
    if (err > 32767) return 32767;
    if (err < -32768) return -32768;
    return int'(err);
`else
    return x;
`endif
  endfunction

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // driver tasks (all input changes happen on the falling edge)
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse();
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic strobes(input int n);
    repeat (n) begin
      pulse();
      idle(3);
    end
  endtask

  // One decimation window with an empty FIFO and out_ready low, so an early
  // capture would show up in level; then pop the result.
  task automatic window_check(input string tag, input int exp);
    strobes(DECIM - 1);
    check({tag, "_early"}, level, 0);
    pulse();
    check({tag, "_e0"}, bus.out_valid, 0);
    idle(1);
    check({tag, "_valid"}, bus.out_valid, 1);
    check({tag, "_data"}, bus.out_data, exp);
    void'(model_y(int'(din) * 16));
    bus.out_ready = 1'b1;
    idle(1);
    bus.out_ready = 1'b0;
    check({tag, "_pop"}, level, 0);
  endtask

  task automatic fill_window(input int d, input bit keep);
    int yv;
    din = 12'(d);
    strobes(DECIM);
    yv = model_y(d * 16);
    if (keep) exp_q.push_back(cic_sample_t'(yv));
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) begin
      check({tag, "_v"}, bus.out_valid, 1);
      check({tag, "_d"}, bus.out_data, exp_q.pop_front());
      bus.out_ready = 1'b1;
      idle(1);
      bus.out_ready = 1'b0;
    end
    check({tag, "_empty"}, level, 0);
  endtask

`ifdef CIC_DECIM_DC_BLOCK_EN
  task automatic fast_window(output logic signed [15:0] yo);
    in_valid = 1'b1;
    repeat (DECIM) @(negedge clk);
    in_valid = 1'b0;
    idle(1);
    check("fast_valid", bus.out_valid, 1);
    yo = bus.out_data;
  endtask
`endif

  initial begin
    rst = 1'b0;
    enable = 1'b0;
    in_valid = 1'b0;
    din = '0;
    clr_ovf = 1'b0;
    bus.out_ready = 1'b0;
`ifdef CIC_DECIM_DC_BLOCK_EN
    dc_m = 0;
`endif
    idle(2);

    // reset state
    check("rst_valid", bus.out_valid, 0);
    check("rst_data", bus.out_data, 0);
    check("rst_level", level, 0);
    check("rst_ovf", overflow, 0);
    rst = 1'b1;
    enable = 1'b1;
    din = 12'sd100;
    idle(1);

    // constant input, one output per window, 2 clk latency
    window_check("w1", 1600);
    window_check("w2", EXP_W2);
    window_check("w3", EXP_W3);

    // disable mid-window: phase restarts at 0, no capture while low
    strobes(10);
    enable = 1'b0;
    strobes(5);
    enable = 1'b1;
    window_check("en", EXP_W4);

    // overflow: 5 samples into a 4-deep FIFO
    for (int k = 1; k <= 5; k++) begin
      if (k == 5) check("ovf_before", overflow, 0);
      fill_window(k * 10, k <= 4);
    end
    check("ovf_level", level, 4);
    check("ovf_set", overflow, 1);
    drain("ovf_rd");
    check("ovf_sticky", overflow, 1);
    clr_ovf = 1'b1;
    idle(1);
    clr_ovf = 1'b0;
    check("ovf_clr", overflow, 0);

    // drop and clear in the same cycle: drop wins
    for (int k = 1; k <= 4; k++) fill_window(-k * 37, 1'b1);
    din = 12'sd500;
    strobes(DECIM - 1);
    pulse();
    clr_ovf = 1'b1;
    idle(1);
    clr_ovf = 1'b0;
    void'(model_y(500 * 16));
    check("race_ovf", overflow, 1);
    check("race_level", level, 4);
    clr_ovf = 1'b1;
    idle(1);
    clr_ovf = 1'b0;
    check("race_clr", overflow, 0);

    // full FIFO with pop and push in the same cycle
    din = 12'sd600;
    strobes(DECIM - 1);
    pulse();
    check("pp_head", bus.out_data, exp_q[0]);
    bus.out_ready = 1'b1;
    idle(1);
    bus.out_ready = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(cic_sample_t'(model_y(600 * 16)));
    check("pp_level", level, 4);
    check("pp_ovf", overflow, 0);
    drain("pp_rd");

    // reset mid-window with two entries queued
    fill_window(7, 1'b1);
    fill_window(8, 1'b1);
    din = 12'sd100;
    strobes(17);
    check("mid_level", level, 2);
    rst = 1'b0;
    #1;
    check("mid_valid", bus.out_valid, 0);
    check("mid_data", bus.out_data, 0);
    check("mid_level0", level, 0);
    check("mid_ovf", overflow, 0);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
`ifdef CIC_DECIM_DC_BLOCK_EN
    dc_m = 0;
`endif
    idle(1);
    window_check("post_rst", 1600);

`ifdef CIC_DECIM_DC_BLOCK_EN
    // DC removal on a constant input
    rst = 1'b0;
    idle(1);
    rst = 1'b1;
    dc_m = 0;
    bus.out_ready = 1'b1;
    din = 12'sd100;
    fast_window(y);
    check("conv_1", y, 1600);
    void'(model_y(1600));
    fast_window(y);
    check("conv_2", y, 1575);
    void'(model_y(1600));
    prev = y;
    for (int i = 2; i < 1000; i++) begin
      fast_window(y);
      check("conv_model", y, model_y(1600));
      check("conv_mono", (y <= prev) ? 1 : 0, 1);
      prev = y;
    end
    check("conv_final", (y >= -64 && y <= 64) ? 1 : 0, 1);

    // full-scale step: saturate, never wrap positive
    din = 12'sd2047;
    for (int i = 0; i < 500; i++) begin
      fast_window(y);
      void'(model_y(32752));
    end
    check("sat_settle", (y >= -64 && y <= 64) ? 1 : 0, 1);
    din = -12'sd2048;
    fast_window(y);
    check("sat_first", y, -32768);
    void'(model_y(-32768));
    for (int i = 0; i < 20; i++) begin
      fast_window(y);
      check("sat_model", y, model_y(-32768));
      check("sat_sign", (y <= 0) ? 1 : 0, 1);
    end
    bus.out_ready = 1'b0;
`endif

    // report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
